tx_core: RTL and testbench

//  Transmit half of the self-defined UART core: buffers bytes written by the host
//  in a byte FIFO and serialises each one onto the Tx wire as a frame:

---
 rtl/uart_pkg.sv | 19 +
 rtl/tx_byte_fifo.sv | 63 ++++++
 rtl/tx_core.sv | 156 +++++++++++++++
 tb/tb_tx_core.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Constants shared by the UART transmit and receive cores.
package uart_pkg;

    localparam int DATA_BITS = 8;

    // Parity method encodings, decoded identically by the receive FSM
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Serialiser / deserialiser state encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/tx_byte_fifo.sv
// Byte FIFO for the transmit path: RAM storage, wrap-bit pointers and
// registered full/empty flags.
module tx_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] data_i,
    input  logic                 we_i,
    input  logic                 pop_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [AW:0]          wr_ptr_q, wr_ptr_d;
    logic [AW:0]          rd_ptr_q, rd_ptr_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic                 wr_en, rd_en;

    assign wr_en   = we_i && !full_q;
    assign rd_en   = pop_i && !empty_q;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign full_o  = full_q;
    assign empty_o = empty_q;

    // Pointer advance; flags are derived from the next pointers so they settle with them
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        if (rd_en) rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    // Pointer and flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage; contents need no reset since the pointers gate every read
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/tx_core.sv
// UART transmit core: byte FIFO feeding a baud-tick driven frame serialiser.
module tx_core
    import uart_pkg::*;
#(
    parameter int DEPTH     = 128,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data_i,
    input  logic                 n_we_i,
    output logic                 p_full_o,
    output logic                 p_empty_o,
    input  logic                 p_BaudSig_i,
    input  logic                 p_ParityEnable_i,
    input  logic                 ParityMethod_i,
    input  logic                 p_BigEnd_i,
    output logic                 p_Busy_o,
    output logic                 Tx_o
);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] byte_q, byte_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 par_en_q, par_en_d;
    logic                 par_odd_q, par_odd_d;
    logic                 big_q, big_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 start_frame, pop;
    logic [DATA_BITS-1:0] fifo_dout;
    logic                 next_bit;
    logic [DATA_BITS-1:0] shifted;

    tx_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .data_i  (data_i),
        .we_i    (!n_we_i),
        .pop_i   (pop),
        .data_o  (fifo_dout),
        .full_o  (p_full_o),
        .empty_o (p_empty_o)
    );

    assign Tx_o     = tx_q;
    assign p_Busy_o = busy_q;
    assign next_bit = big_q ? shift_q[DATA_BITS-1] : shift_q[0];
    assign shifted  = big_q ? {shift_q[DATA_BITS-2:0], 1'b0} : {1'b0, shift_q[DATA_BITS-1:1]};

    // Frame sequencing; every transition waits for a baud tick
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        byte_d      = byte_q;
        cnt_d       = cnt_q;
        stop_cnt_d  = stop_cnt_q;
        par_en_d    = par_en_q;
        par_odd_d   = par_odd_q;
        big_d       = big_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        start_frame = 1'b0;
        pop         = 1'b0;
        if (p_BaudSig_i) begin
            case (state_q)
                ST_IDLE: start_frame = !p_empty_o;
                ST_START: begin
                    tx_d    = next_bit;
                    shift_d = shifted;
                    state_d = ST_DATA;
                end
                ST_DATA: begin
                    if (cnt_q == 4'(DATA_BITS - 1)) begin
                        stop_cnt_d = 1'b0;
                        if (par_en_q) begin
                            tx_d    = (^byte_q) ^ par_odd_q;
                            state_d = ST_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = ST_STOP;
                        end
                    end else begin
                        tx_d    = next_bit;
                        shift_d = shifted;
                        cnt_d   = cnt_q + 4'd1;
                    end
                end
                ST_PARITY: begin
                    tx_d    = 1'b1;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        if (!p_empty_o) begin
                            start_frame = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            endcase
        end
        // Pop the next byte and freeze the configuration for the whole frame
        if (start_frame) begin
            pop       = 1'b1;
            shift_d   = fifo_dout;
            byte_d    = fifo_dout;
            par_en_d  = p_ParityEnable_i;
            par_odd_d = (ParityMethod_i == PAR_ODD);
            big_d     = p_BigEnd_i;
            cnt_d     = 4'd0;
            tx_d      = 1'b0;
            busy_d    = 1'b1;
            state_d   = ST_START;
        end
    end

    // Serialiser registers; reset drives the line straight to idle-high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            byte_q     <= '0;
            cnt_q      <= 4'd0;
            stop_cnt_q <= 1'b0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            big_q      <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            byte_q     <= byte_d;
            cnt_q      <= cnt_d;
            stop_cnt_q <= stop_cnt_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            big_q      <= big_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_tx_core.sv
// Directed bench for tx_core: single-frame vector table plus hand-written
// back-to-back, overflow, reset and mid-frame config sequences.
module tb_tx_core;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_i;
    logic       n_we_i;
    logic       p_full_o, p_empty_o;
    logic       p_BaudSig_i;
    logic       p_ParityEnable_i, ParityMethod_i, p_BigEnd_i;
    logic       p_Busy_o, Tx_o;

    int checks   = 0;
    int failures = 0;

    tx_core #(.DEPTH(DEPTH), .STOP_BITS(1)) dut (
        .clk              (clk),
        .rst              (rst),
        .data_i           (data_i),
        .n_we_i           (n_we_i),
        .p_full_o         (p_full_o),
        .p_empty_o        (p_empty_o),
        .p_BaudSig_i      (p_BaudSig_i),
        .p_ParityEnable_i (p_ParityEnable_i),
        .ParityMethod_i   (ParityMethod_i),
        .p_BigEnd_i       (p_BigEnd_i),
        .p_Busy_o         (p_Busy_o),
        .Tx_o             (Tx_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       big;
        logic       pen;
        logic       podd;
    } vec_t;

    vec_t  vecs [6];
    string seqs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] b);
        @(negedge clk);
        data_i = b;
        n_we_i = 1'b0;
        @(negedge clk);
        n_we_i = 1'b1;
    endtask

    // One baud tick, outputs sampled at the following falling edge
    task automatic tick(output logic tx, output logic busy);
        @(negedge clk);
        p_BaudSig_i = 1'b1;
        @(negedge clk);
        p_BaudSig_i = 1'b0;
        tx   = Tx_o;
        busy = p_Busy_o;
        @(negedge clk);
    endtask

    // Tick through a frame string and compare each line bit, busy held high throughout
    task automatic run_seq(input string name, input string s);
        logic tx, busy;
        for (int i = 0; i < s.len(); i++) begin
            tick(tx, busy);
            chk($sformatf("%s tx[%0d]", name, i), {31'd0, tx}, {31'd0, s[i] == 8'h31});
            chk($sformatf("%s busy[%0d]", name, i), {31'd0, busy}, 32'd1);
        end
    endtask

    task automatic end_idle(input string name);
        logic tx, busy;
        tick(tx, busy);
        chk({name, " idle tx"}, {31'd0, tx}, 32'd1);
        chk({name, " idle busy"}, {31'd0, busy}, 32'd0);
        chk({name, " idle empty"}, {31'd0, p_empty_o}, 32'd1);
    endtask

    initial begin
        logic tx, busy;
        logic [7:0] got;

        // start, data bits in line order, [parity], stop
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0}; seqs[0] = "0101001011";
        vecs[1] = '{8'h81, 1'b1, 1'b1, 1'b0}; seqs[1] = "01000000101";
        vecs[2] = '{8'h81, 1'b1, 1'b1, 1'b1}; seqs[2] = "01000000111";
        vecs[3] = '{8'h3C, 1'b0, 1'b1, 1'b1}; seqs[3] = "00011110011";
        vecs[4] = '{8'h01, 1'b1, 1'b0, 1'b0}; seqs[4] = "0000000011";
        vecs[5] = '{8'h80, 1'b0, 1'b1, 1'b0}; seqs[5] = "00000000111";

        rst = 1'b0; data_i = 8'h00; n_we_i = 1'b1; p_BaudSig_i = 1'b0;
        p_ParityEnable_i = 1'b0; ParityMethod_i = 1'b0; p_BigEnd_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst tx", {31'd0, Tx_o}, 32'd1);
        chk("rst busy", {31'd0, p_Busy_o}, 32'd0);
        chk("rst empty", {31'd0, p_empty_o}, 32'd1);
        chk("rst full", {31'd0, p_full_o}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Tick with empty FIFO does nothing
        tick(tx, busy);
        chk("empty tick tx", {31'd0, tx}, 32'd1);
        chk("empty tick busy", {31'd0, busy}, 32'd0);

        // Single-frame table
        for (int v = 0; v < 6; v++) begin
            p_BigEnd_i = vecs[v].big;
            p_ParityEnable_i = vecs[v].pen;
            ParityMethod_i = vecs[v].podd;
            wr(vecs[v].data);
            chk($sformatf("v%0d empty after write", v), {31'd0, p_empty_o}, 32'd0);
            run_seq($sformatf("v%0d", v), seqs[v]);
            end_idle($sformatf("v%0d", v));
        end

        // Back-to-back frames from writes in consecutive clocks
        p_BigEnd_i = 1'b0; p_ParityEnable_i = 1'b0; ParityMethod_i = 1'b0;
        @(negedge clk);
        data_i = 8'h00; n_we_i = 1'b0;
        @(negedge clk);
        data_i = 8'hFF;
        @(negedge clk);
        n_we_i = 1'b1;
        run_seq("b2b", "00000000010111111111");
        end_idle("b2b");

        // Overflow: DEPTH+3 writes without ticks
        for (int i = 0; i < DEPTH + 3; i++) begin
            wr(8'(i + 1));
            if (i == DEPTH - 2) chk("full before DEPTH", {31'd0, p_full_o}, 32'd0);
            if (i == DEPTH - 1) chk("full at DEPTH", {31'd0, p_full_o}, 32'd1);
        end
        chk("full after extra", {31'd0, p_full_o}, 32'd1);
        for (int f = 0; f < DEPTH; f++) begin
            tick(tx, busy);
            chk($sformatf("drain%0d start", f), {31'd0, tx}, 32'd0);
            if (f == 1) chk("full cleared", {31'd0, p_full_o}, 32'd0);
            tick(tx, busy);
            for (int b = 0; b < 8; b++) begin
                got[b] = tx;
                tick(tx, busy);
            end
            chk($sformatf("drain%0d byte", f), {24'd0, got}, 32'(f + 1));
            chk($sformatf("drain%0d stop", f), {31'd0, tx}, 32'd1);
            chk($sformatf("drain%0d busy", f), {31'd0, busy}, 32'd1);
        end
        end_idle("drain");

        // Reset mid-DATA with a second byte still queued
        wr(8'h00);
        wr(8'h55);
        for (int i = 0; i < 4; i++) tick(tx, busy);
        chk("pre-rst tx low", {31'd0, tx}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid rst tx", {31'd0, Tx_o}, 32'd1);
        chk("mid rst busy", {31'd0, p_Busy_o}, 32'd0);
        chk("mid rst empty", {31'd0, p_empty_o}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(tx, busy);
            chk($sformatf("post rst tx[%0d]", i), {31'd0, tx}, 32'd1);
            chk($sformatf("post rst busy[%0d]", i), {31'd0, busy}, 32'd0);
        end

        // Config flip mid-frame affects only the next frame
        wr(8'hA5);
        wr(8'h81);
        run_seq("cfg f1a", "0101");
        p_BigEnd_i = 1'b1; p_ParityEnable_i = 1'b1; ParityMethod_i = 1'b0;
        run_seq("cfg f1b", "001011");
        run_seq("cfg f2", "01000000101");
        end_idle("cfg");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
